// File: rtl/rv32v_pkg.sv
// Shared scalar/vector core constants: data width, register file geometry
// and the fixed writeback-producer indices used by the X-file arbiter.
package rv32v_pkg;

    localparam int XLEN    = 32;
    localparam int NREG    = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 3;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_VMV = 2;

endpackage

// File: rtl/x_wb_arbiter_rr.sv
// Round-robin arbiter: N requests in, one-hot grant out.
// Ports: clk, rst_n, req[N] requests, adv advance pointer, gnt[N] grant.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    logic [LW-1:0] last;
    logic [LW-1:0] nxt;

    // Search starts one past the last winner so that winner goes last.
    always_comb begin : pick
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        gnt   = '0;
        nxt   = last;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt      = LW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= LW'(N - 1);
        end else if (adv) begin
            last <= nxt;
        end
    end

endmodule

// File: rtl/x_wb_arbiter.sv
// X register file writeback arbiter: round-robin grant of NUM_SRC producers
// into one registered write port, plus a pending-write busy scoreboard.
// Ports: src_valid/src_ready/src_rd/src_data producer side; iss_valid/iss_rd
// issue-side scoreboard set; busy per-register pending; reg_w/rd/w_data file.
module x_wb_arbiter
    import rv32v_pkg::*;
#(
    parameter int NUM_SRC = rv32v_pkg::NUM_SRC,
    parameter int XLEN    = rv32v_pkg::XLEN,
    parameter int NREG    = rv32v_pkg::NREG
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic [NUM_SRC*REG_AW-1:0] src_rd,
    input  logic [NUM_SRC*XLEN-1:0]  src_data,
    input  logic                     iss_valid,
    input  logic [REG_AW-1:0]        iss_rd,
    output logic [NREG-1:0]          busy,
    output logic                     reg_w,
    output logic [REG_AW-1:0]        rd,
    output logic [XLEN-1:0]          w_data
);

    logic [NUM_SRC-1:0] gnt;
    logic               hs;
    logic [REG_AW-1:0]  sel_rd;
    logic [XLEN-1:0]    sel_data;
    logic               sel_wr;
    logic [NREG-1:0]    busy_nxt;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (src_valid),
        .adv   (hs),
        .gnt   (gnt)
    );

    assign src_ready = gnt;
    assign hs        = |(src_valid & gnt);

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                sel_rd   = src_rd[REG_AW*i +: REG_AW];
                sel_data = src_data[XLEN*i +: XLEN];
            end
        end
    end

    // x0 writebacks complete the handshake but never reach the file.
    assign sel_wr = hs && (sel_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_w  <= 1'b0;
            rd     <= '0;
            w_data <= '0;
        end else begin
            reg_w <= sel_wr;
            if (sel_wr) begin
                rd     <= sel_rd;
                w_data <= sel_data;
            end
        end
    end

    // Clear first, then set, so a same-edge issue keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (reg_w) begin
            busy_nxt[rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule
